// File: rtl/updn_terminal_counter.sv
// Up/down counter with a programmable terminal count. It can wrap or saturate
// at the boundaries, and it raises a one-cycle terminal pulse and sticky overflow/underflow flags.
module updn_terminal_counter #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_value,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] count_out,
    output logic             tc_pulse,
    output logic             overflow_flag,
    output logic             underflow_flag,
    output logic             at_max,
    output logic             at_zero
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             up_evt, dn_evt;

    // Boundary events are only possible on an enabled step without a load.
    assign up_evt = !load && enable &&  up_dn && (count_q >= max_value);
    assign dn_evt = !load && enable && !up_dn && (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_value;
        else if (up_evt)
            count_d = SATURATE ? max_value : '0;
        else if (dn_evt)
            count_d = SATURATE ? '0 : max_value;
        else if (enable && up_dn)
            count_d = count_q + WIDTH'(1);
        else if (enable)
            count_d = count_q - WIDTH'(1);
    end

    // A boundary event in the same cycle as clear_flags keeps its flag set.
    assign tc_d  = up_evt || dn_evt;
    assign ovf_d = (ovf_q && !clear_flags) || up_evt;
    assign unf_d = (unf_q && !clear_flags) || dn_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count_out      = count_q;
    assign tc_pulse       = tc_q;
    assign overflow_flag  = ovf_q;
    assign underflow_flag = unf_q;
    assign at_max         = (count_q >= max_value);
    assign at_zero        = (count_q == '0);

endmodule

// File: doc/updn_terminal_counter.md
UPDN_TERMINAL_COUNTER -- requirements
Module: updn_terminal_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter SATURATE, default 0, where 0 means wrap at the boundary and 1 means hold at the boundary.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 enable  input  1  count-step request for the current cycle.
REQ-006 up_dn  input  1  count direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_value  input  WIDTH  value written to the count when load=1.
REQ-009 max_value  input  WIDTH  programmable terminal count, sampled every cycle.
REQ-010 clear_flags  input  1  clears both sticky flags.
REQ-011 count_out  output  WIDTH  registered counter value.
REQ-012 tc_pulse  output  1  registered one-cycle strobe for a boundary event.
REQ-013 overflow_flag  output  1  registered sticky flag for an up-boundary event.
REQ-014 underflow_flag  output  1  registered sticky flag for a down-boundary event.
REQ-015 at_max  output  1  combinational: count_out >= max_value.
REQ-016 at_zero  output  1  combinational: count_out == 0.

Function
REQ-017 Per-edge priority SHALL be: reset, then load, then enable; with load=0 and enable=0 the count holds.
REQ-018 load=1 SHALL set count_out to load_value on the next edge, regardless of enable or up_dn, and SHALL NOT raise tc_pulse or either flag.
REQ-019 An up step SHALL apply when enable=1, up_dn=1 and count_out < max_value; count_out then increments by 1.
REQ-020 An up-boundary event SHALL occur when enable=1, up_dn=1 and count_out >= max_value.
REQ-021 On an up-boundary event, the next count SHALL be 0 when SATURATE=0 and max_value when SATURATE=1.
REQ-022 A down step SHALL apply when enable=1, up_dn=0 and count_out != 0; count_out then decrements by 1, including when count_out > max_value.
REQ-023 A down-boundary event SHALL occur when enable=1, up_dn=0 and count_out == 0.
REQ-024 On a down-boundary event, the next count SHALL be max_value when SATURATE=0 and 0 when SATURATE=1.
REQ-025 A boundary event SHALL set tc_pulse to 1 for exactly the cycle in which count_out shows the post-event value; otherwise tc_pulse SHALL be 0.
REQ-026 An up-boundary event SHALL set overflow_flag, a down-boundary event SHALL set underflow_flag, and both flags SHALL hold until reset or clear_flags.
REQ-027 clear_flags together with a same-cycle boundary event SHALL leave the corresponding flag set (set wins).
REQ-028 With max_value = 0 and SATURATE=0, every enabled step in either direction SHALL be a boundary event with count 0.
REQ-029 A change to max_value SHALL take effect on the next edge with no other side effect.
REQ-030 All arithmetic SHALL be modulo 2^WIDTH; no step SHALL produce a value outside 0..2^WIDTH-1.
REQ-031 There SHALL be no intra-assignment delays and no X propagation after the first reset.

Reset
REQ-032 reset=1 SHALL drive count_out=0, tc_pulse=0, overflow_flag=0 and underflow_flag=0 on the next edge, overriding load, enable and clear_flags.
REQ-033 reset asserted mid-count SHALL abort the operation with no residual tc_pulse in the following cycle.
REQ-034 After reset, at_zero SHALL be 1 and at_max SHALL equal (max_value == 0).

Verification
REQ-035 WIDTH=4, SATURATE=0, max_value=9, up, enable held 12 cycles from 0 -> count 0..9, then 0, 1; tc_pulse high only in the cycle count shows 0; overflow_flag=1 thereafter.
REQ-036 WIDTH=4, SATURATE=1, max_value=15, up from 14 for 3 cycles -> count 15, 15, 15; tc_pulse high for 2 cycles; overflow_flag=1.
REQ-037 SATURATE=0, max_value=5, down from 1 for 3 cycles -> count 0, 5, 4; underflow_flag=1; tc_pulse high only when count shows 5.
REQ-038 load=1, load_value=12, enable=1 with max_value=9 in the same cycle -> count 12 and no tc_pulse; next up step -> count 0, tc_pulse=1.
REQ-039 clear_flags=1 in the same cycle as an up-boundary event -> overflow_flag stays 1; clear_flags alone on the next cycle -> overflow_flag=0.
REQ-040 reset=1 at count 7 with load=1 and overflow_flag=1 -> next cycle count 0, all flags 0, tc_pulse 0.
